// File: rtl/uart_msg_pkg.sv
// -----------------------------------------------------------------------------
// uart_msg_pkg
// Shared definitions for the UART message scheduler:
//   - message IDs for the canned status strings
//   - per-ID start offset and length inside the message ROM
//   - scheduler state encoding
// -----------------------------------------------------------------------------
package uart_msg_pkg;

    localparam int MSG_RED_ON    = 0;
    localparam int MSG_RED_OFF   = 1;
    localparam int MSG_GREEN_ON  = 2;
    localparam int MSG_GREEN_OFF = 3;
    localparam int MSG_BLUE_ON   = 4;
    localparam int MSG_BLUE_OFF  = 5;
    localparam int NUM_MSG       = 6;

    // Total bytes stored back to back in the ROM.
    localparam int ROM_BYTES = 57;

    // Start offset and length of each message, indexed by message ID.
    localparam int MSG_START [NUM_MSG] = '{0, 8, 17, 27, 38, 47};
    localparam int MSG_LEN   [NUM_MSG] = '{8, 9, 10, 11, 9, 10};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_ACK
    } state_t;

endpackage

// File: rtl/uart_msg_rom.sv
// -----------------------------------------------------------------------------
// uart_msg_rom
// Combinational message ROM. Holds the six status strings back to back and
// reports where a given message lives plus the byte at an absolute address.
//   msg_id  in  : message ID; IDs of NUM_MSG or above report start 0, len 0
//   addr    in  : absolute ROM byte address
//   start   out : first byte address of msg_id
//   len     out : byte count of msg_id
//   data    out : ROM byte at addr (0 beyond the stored text)
// -----------------------------------------------------------------------------
module uart_msg_rom
    import uart_msg_pkg::*;
#(
    parameter int MSG_ID_W   = 3,
    parameter int ROM_ADDR_W = 6
) (
    input  logic [MSG_ID_W-1:0]   msg_id,
    input  logic [ROM_ADDR_W-1:0] addr,
    output logic [ROM_ADDR_W-1:0] start,
    output logic [ROM_ADDR_W-1:0] len,
    output logic [7:0]            data
);

    // First character sits in the most significant byte.
    localparam logic [8*ROM_BYTES-1:0] ROM_TEXT = {
        "Red ON",    8'h0D, 8'h0A,
        "Red OFF",   8'h0D, 8'h0A,
        "Green ON",  8'h0D, 8'h0A,
        "Green OFF", 8'h0D, 8'h0A,
        "Blue ON",   8'h0D, 8'h0A,
        "Blue OFF",  8'h0D, 8'h0A
    };

    always_comb begin
        // NOTE: every output gets a default before any conditional assignment,
        // otherwise unmatched IDs/addresses would infer latches.
        start = '0;
        len   = '0;
        for (int i = 0; i < NUM_MSG; i++) begin
            if (msg_id == MSG_ID_W'(i)) begin
                start = ROM_ADDR_W'(MSG_START[i]);
                len   = ROM_ADDR_W'(MSG_LEN[i]);
            end
        end
    end

    always_comb begin
        data = 8'h00;
        for (int i = 0; i < ROM_BYTES; i++) begin
            if (addr == ROM_ADDR_W'(i)) data = ROM_TEXT[(ROM_BYTES-1-i)*8 +: 8];
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one byte-wide UART transmitter between NUM_REQ requesters. Each
// requester asks for a whole canned message by ID; a round-robin arbiter picks
// one, the bytes are walked out of uart_msg_rom one transmit handshake at a
// time, and the requester gets a one-cycle ack when its last byte has left.
//   clk, rst          : clock, asynchronous active-high reset
//   req               : level request per requester, held until ack
//   req_msg           : message ID per requester, slice i at [i*MSG_ID_W +: MSG_ID_W]
//   ack               : one-cycle completion pulse on the granted bit
//   busy              : high from grant through the ack cycle
//   grant_id          : current or last granted requester
//   transmit, tx_byte : UART byte strobe and data
//   is_transmitting   : UART busy flag
// -----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_msg_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MSG_ID_W   = 3,
    parameter int ROM_ADDR_W = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*MSG_ID_W-1:0]  req_msg,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         transmit,
    output logic [7:0]                   tx_byte,
    input  logic                         is_transmitting
);

    localparam int GID_W = $clog2(NUM_REQ);

    state_t                state, state_n;
    logic [GID_W-1:0]      ptr, ptr_n;
    logic [GID_W-1:0]      grant_id_n;
    logic [ROM_ADDR_W-1:0] addr, addr_n;
    logic [ROM_ADDR_W-1:0] remaining, remaining_n;
    logic [NUM_REQ-1:0]    ack_n;
    logic                  busy_n;
    logic                  transmit_n;
    logic [7:0]            tx_byte_n;

    logic [2*NUM_REQ-1:0]  req_rot;
    logic [GID_W-1:0]      pick;
    logic                  pick_valid;
    logic [MSG_ID_W-1:0]   rom_id;
    logic [ROM_ADDR_W-1:0] rom_start;
    logic [ROM_ADDR_W-1:0] rom_len;
    logic [7:0]            rom_data;

    // Round-robin pick: rotate the request vector so the pointer lands at
    // bit 0, then take the lowest set bit and map it back to an index.
    always_comb begin
        req_rot    = {req, req} >> ptr;
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_valid && req_rot[k]) begin
                pick_valid = 1'b1;
                pick       = GID_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    // The ROM only needs a message ID at grant time; afterwards addr is
    // absolute, so the requester's ID may change without effect.
    always_comb begin
        rom_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick == GID_W'(k)) rom_id = req_msg[k*MSG_ID_W +: MSG_ID_W];
        end
    end

    uart_msg_rom #(
        .MSG_ID_W  (MSG_ID_W),
        .ROM_ADDR_W(ROM_ADDR_W)
    ) u_rom (
        .msg_id(rom_id),
        .addr  (addr),
        .start (rom_start),
        .len   (rom_len),
        .data  (rom_data)
    );

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        grant_id_n  = grant_id;
        addr_n      = addr;
        remaining_n = remaining;
        ack_n       = '0;
        busy_n      = busy;
        transmit_n  = 1'b0;
        tx_byte_n   = tx_byte;

        unique case (state)
            ST_IDLE: begin
                // busy drops here, one cycle after the ack, unless a new
                // grant keeps it high.
                busy_n = 1'b0;
                if (pick_valid) begin
                    grant_id_n  = pick;
                    addr_n      = rom_start;
                    remaining_n = rom_len;
                    busy_n      = 1'b1;
                    state_n     = (rom_len == '0) ? ST_ACK : ST_SEND;
                end
            end
            ST_SEND: begin
                if (!is_transmitting) begin
                    transmit_n  = 1'b1;
                    tx_byte_n   = rom_data;
                    addr_n      = addr + ROM_ADDR_W'(1);
                    remaining_n = remaining - ROM_ADDR_W'(1);
                    state_n     = ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                if (is_transmitting) state_n = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!is_transmitting) state_n = (remaining == '0) ? ST_ACK : ST_SEND;
            end
            ST_ACK: begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (grant_id == GID_W'(k)) ack_n[k] = 1'b1;
                end
                ptr_n   = (grant_id == GID_W'(NUM_REQ-1)) ? '0 : grant_id + GID_W'(1);
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            grant_id  <= '0;
            addr      <= '0;
            remaining <= '0;
            ack       <= '0;
            busy      <= 1'b0;
            transmit  <= 1'b0;
            tx_byte   <= 8'h00;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            grant_id  <= grant_id_n;
            addr      <= addr_n;
            remaining <= remaining_n;
            ack       <= ack_n;
            busy      <= busy_n;
            transmit  <= transmit_n;
            tx_byte   <= tx_byte_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Self-checking bench for uart_tx_scheduler. A small UART model answers the
// transmit strobe with a randomly sized busy window; a monitor collects the
// bytes sent and the acks. Expected strings and service order come from the
// message text table and a round-robin model kept here.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int NR  = 4;
    localparam int IDW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req = '0;
    logic [NR*IDW-1:0] req_msg = '0;
    logic [NR-1:0] ack;
    logic          busy;
    logic [1:0]    grant_id;
    logic          transmit;
    logic [7:0]    tx_byte;
    logic          is_tx = 1'b0;

    int checks = 0;
    int errors = 0;

    // monitor / UART model state
    int    uart_cnt = 0;
    bit    force_busy = 1'b0;
    int    tx_count = 0;
    int    tx_while_busy = 0;
    int    multi_ack = 0;
    string cur = "";
    int    ack_idx_q[$];
    string ack_msg_q[$];

    // round-robin pointer model
    int model_ptr = 0;

    uart_tx_scheduler #(.NUM_REQ(NR), .MSG_ID_W(IDW), .ROM_ADDR_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_msg        (req_msg),
        .ack            (ack),
        .busy           (busy),
        .grant_id       (grant_id),
        .transmit       (transmit),
        .tx_byte        (tx_byte),
        .is_transmitting(is_tx)
    );

    always #5 clk = ~clk;

    // UART model and monitor, evaluated on the falling edge.
    always @(negedge clk) begin
        if (transmit === 1'b1) begin
            tx_count++;
            if (is_tx) tx_while_busy++;
            cur = {cur, " "};
            cur.putc(cur.len() - 1, tx_byte);
            uart_cnt = $urandom_range(3, 20);
        end else if (uart_cnt > 0) begin
            uart_cnt--;
        end
        is_tx = force_busy || (uart_cnt > 0);
        if (!rst && ack !== '0) begin
            if ($countones(ack) != 1) multi_ack++;
            for (int i = 0; i < NR; i++) begin
                if (ack[i]) begin
                    ack_idx_q.push_back(i);
                    ack_msg_q.push_back(cur);
                end
            end
            cur = "";
        end
        if (rst) cur = "";
    end

    function automatic string msg_text(int id);
        string s;
        case (id)
            0: s = "Red ON";
            1: s = "Red OFF";
            2: s = "Green ON";
            3: s = "Green OFF";
            4: s = "Blue ON";
            5: s = "Blue OFF";
            default: return "";
        endcase
        s = {s, "  "};
        s.putc(s.len() - 2, 8'h0D);
        s.putc(s.len() - 1, 8'h0A);
        return s;
    endfunction

    function automatic string hexs(string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h", s[i])};
        return r;
    endfunction

    task automatic set_id(int i, int id);
        req_msg[i*IDW +: IDW] = IDW'(id);
    endtask

    task automatic clear_logs();
        ack_idx_q.delete();
        ack_msg_q.delete();
        cur = "";
        tx_count = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
        model_ptr = 0;
        clear_logs();
    endtask

    // Waits for n acks, dropping each acked request. Timeout counts as a failure.
    task automatic wait_acks(int n, int budget, string name);
        int c = 0;
        while (ack_idx_q.size() < n && c < budget) begin
            tick();
            c++;
            for (int i = 0; i < NR; i++) if (ack[i]) req[i] = 1'b0;
        end
        checks++;
        if (ack_idx_q.size() < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d acks, want %0d", name, ack_idx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        tick();
        checks += 5;
        if (ack !== '0)       begin errors++; $display("FAIL reset ack: got %b want 0", ack); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        if (grant_id !== '0)  begin errors++; $display("FAIL reset grant_id: got %0d want 0", grant_id); end
        if (transmit !== 1'b0) begin errors++; $display("FAIL reset transmit: got %b want 0", transmit); end
        if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset tx_byte: got %h want 00", tx_byte); end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || transmit !== 1'b0) begin
            errors++; $display("FAIL idle after reset: busy %b transmit %b, want 0 0", busy, transmit);
        end
        clear_logs();
    endtask

    task automatic test_single();
        int c = 0;
        string exp = msg_text(0);
        set_id(0, 0);
        req[0] = 1'b1;
        while (busy !== 1'b1 && c < 20) begin tick(); c++; end
        checks++;
        if (c != 1) begin errors++; $display("FAIL single grant latency: got %0d want 1", c); end
        tick();
        checks++;
        if (transmit !== 1'b1 || tx_byte !== 8'h52) begin
            errors++; $display("FAIL single first byte: got transmit %b byte %h want 1 52", transmit, tx_byte);
        end
        wait_acks(1, 2000, "single");
        checks += 3;
        if (ack !== 4'b0001) begin errors++; $display("FAIL single ack: got %b want 0001", ack); end
        if (ack_msg_q.size() > 0 && ack_msg_q[0] != exp) begin
            errors++; $display("FAIL single bytes: got %s want %s", hexs(ack_msg_q[0]), hexs(exp));
        end
        if (tx_count != 8) begin errors++; $display("FAIL single pulses: got %0d want 8", tx_count); end
        tick();
        checks++;
        if (ack !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL single after ack: ack %b busy %b, want 0 0", ack, busy);
        end
        model_ptr = 1;
        clear_logs();
    endtask

    task automatic test_rr();
        int ids[4];
        int exp_idx[4] = '{0, 1, 3, 0};
        int exp_id[4];
        int c = 0;
        bit re_done = 1'b0;
        reset_dut();
        for (int i = 0; i < NR; i++) begin
            ids[i] = $urandom_range(0, 5);
            set_id(i, ids[i]);
        end
        exp_id[0] = ids[0]; exp_id[1] = ids[1]; exp_id[2] = ids[3];
        exp_id[3] = $urandom_range(0, 5);
        req = 4'b1011;
        while (ack_idx_q.size() < 4 && c < 4000) begin
            tick();
            c++;
            for (int i = 0; i < NR; i++) if (ack[i]) req[i] = 1'b0;
            if (!re_done && ack[0]) begin
                re_done = 1'b1;
                set_id(0, exp_id[3]);
                req[0] = 1'b1;
            end
        end
        checks++;
        if (ack_idx_q.size() != 4) begin
            errors++; $display("FAIL rr ack count: got %0d want 4", ack_idx_q.size());
        end
        for (int k = 0; k < 4 && k < ack_idx_q.size(); k++) begin
            checks += 2;
            if (ack_idx_q[k] != exp_idx[k]) begin
                errors++; $display("FAIL rr order[%0d]: got %0d want %0d", k, ack_idx_q[k], exp_idx[k]);
            end
            if (ack_msg_q[k] != msg_text(exp_id[k])) begin
                errors++; $display("FAIL rr bytes[%0d]: got %s want %s", k, hexs(ack_msg_q[k]), hexs(msg_text(exp_id[k])));
            end
        end
        model_ptr = 1;
        tick();
        clear_logs();
    endtask

    task automatic test_invalid();
        int c = 0;
        set_id(2, 7);
        req[2] = 1'b1;
        while (busy !== 1'b1 && c < 20) begin tick(); c++; end
        checks += 2;
        if (ack !== 4'b0000) begin errors++; $display("FAIL invalid ack at grant: got %b want 0000", ack); end
        tick();
        if (ack !== 4'b0100) begin errors++; $display("FAIL invalid ack timing: got %b want 0100", ack); end
        req[2] = 1'b0;
        tick();
        checks += 2;
        if (tx_count != 0) begin errors++; $display("FAIL invalid pulses: got %0d want 0", tx_count); end
        if (busy !== 1'b0) begin errors++; $display("FAIL invalid busy after ack: got %b want 0", busy); end
        model_ptr = 3;
        clear_logs();
    endtask

    task automatic test_mid_request();
        int id0 = $urandom_range(0, 5);
        int id1 = $urandom_range(0, 5);
        int c = 0;
        set_id(0, id0);
        set_id(1, id1);
        req[0] = 1'b1;
        while (tx_count < 1 && c < 200) begin tick(); c++; end
        req[1] = 1'b1;
        wait_acks(2, 4000, "mid");
        checks++;
        if (ack_idx_q.size() == 2 && (ack_idx_q[0] != 0 || ack_idx_q[1] != 1)) begin
            errors++; $display("FAIL mid order: got %0d,%0d want 0,1", ack_idx_q[0], ack_idx_q[1]);
        end
        if (ack_msg_q.size() == 2) begin
            checks += 2;
            if (ack_msg_q[0] != msg_text(id0)) begin
                errors++; $display("FAIL mid bytes req0: got %s want %s", hexs(ack_msg_q[0]), hexs(msg_text(id0)));
            end
            if (ack_msg_q[1] != msg_text(id1)) begin
                errors++; $display("FAIL mid bytes req1: got %s want %s", hexs(ack_msg_q[1]), hexs(msg_text(id1)));
            end
        end
        model_ptr = 2;
        tick();
        clear_logs();
    endtask

    task automatic test_reset_mid();
        int c = 0;
        reset_dut();
        set_id(0, 3);
        req[0] = 1'b1;
        while (tx_count < 3 && c < 500) begin tick(); c++; end
        rst = 1'b1;
        #1;
        checks++;
        if (ack !== '0 || busy !== 1'b0 || grant_id !== '0 || transmit !== 1'b0 || tx_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset mid outputs: ack %b busy %b gid %0d tx %b byte %h, want all 0",
                     ack, busy, grant_id, transmit, tx_byte);
        end
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (ack_idx_q.size() != 0) begin
            errors++; $display("FAIL reset mid ack: got %0d acks want 0", ack_idx_q.size());
        end
        clear_logs();
        model_ptr = 0;
        wait_acks(1, 2000, "restart");
        if (ack_msg_q.size() == 1) begin
            checks += 2;
            if (ack_msg_q[0] != msg_text(3)) begin
                errors++; $display("FAIL restart bytes: got %s want %s", hexs(ack_msg_q[0]), hexs(msg_text(3)));
            end
            if (tx_count != 11) begin errors++; $display("FAIL restart pulses: got %0d want 11", tx_count); end
        end
        model_ptr = 1;
        tick();
        clear_logs();
    endtask

    task automatic test_busy_hold();
        force_busy = 1'b1;
        is_tx = 1'b1;
        tick();
        set_id(3, 4);
        req[3] = 1'b1;
        for (int i = 0; i < 5000; i++) tick();
        checks += 3;
        if (tx_count != 0) begin errors++; $display("FAIL hold pulses: got %0d want 0", tx_count); end
        if (busy !== 1'b1) begin errors++; $display("FAIL hold busy: got %b want 1", busy); end
        if (grant_id !== 2'd3) begin errors++; $display("FAIL hold grant_id: got %0d want 3", grant_id); end
        force_busy = 1'b0;
        wait_acks(1, 2000, "hold");
        if (ack_msg_q.size() == 1) begin
            checks++;
            if (ack_msg_q[0] != msg_text(4)) begin
                errors++; $display("FAIL hold bytes: got %s want %s", hexs(ack_msg_q[0]), hexs(msg_text(4)));
            end
        end
        model_ptr = 0;
        tick();
        clear_logs();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int ids[4];
            int mask = $urandom_range(1, 15);
            int exp_idx[$];
            int p = model_ptr;
            int pend = mask;
            for (int i = 0; i < NR; i++) begin
                ids[i] = $urandom_range(0, 7);
                set_id(i, ids[i]);
            end
            while (pend != 0) begin
                for (int k = 0; k < NR; k++) begin
                    int j = (p + k) % NR;
                    if (pend[j]) begin
                        exp_idx.push_back(j);
                        pend[j] = 1'b0;
                        p = (j + 1) % NR;
                        break;
                    end
                end
            end
            model_ptr = p;
            req = NR'(mask);
            wait_acks(exp_idx.size(), 6000, "random");
            for (int k = 0; k < exp_idx.size() && k < ack_idx_q.size(); k++) begin
                checks += 2;
                if (ack_idx_q[k] != exp_idx[k]) begin
                    errors++; $display("FAIL random it%0d order[%0d]: got %0d want %0d", it, k, ack_idx_q[k], exp_idx[k]);
                end
                if (ack_msg_q[k] != msg_text(ids[exp_idx[k]])) begin
                    errors++;
                    $display("FAIL random it%0d bytes[%0d]: got %s want %s", it, k,
                             hexs(ack_msg_q[k]), hexs(msg_text(ids[exp_idx[k]])));
                end
            end
            tick();
            clear_logs();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_invalid();
        test_mid_request();
        test_reset_mid();
        test_busy_hold();
        test_random();
        checks += 2;
        if (tx_while_busy != 0) begin
            errors++; $display("FAIL transmit while UART busy: got %0d want 0", tx_while_busy);
        end
        if (multi_ack != 0) begin
            errors++; $display("FAIL ack not one-hot: got %0d events want 0", multi_ack);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
